// File: rtl/sound_scheduler.sv
// Sound request scheduler for the single game_sounds player.
// Latches requests, grants by priority, strobes start and times the melody.
module sound_scheduler #(
   parameter int unsigned DUR_SHORT = 2_000_000,
   parameter int unsigned DUR_LONG  = 5_000_000,
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GUARD     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       mute,
   output logic       snd_start_n,
   output logic [1:0] snd_type,
   output logic       busy,
   output logic       overrun
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam logic [31:0] PULSE_LOAD = 32'(PULSE_LEN - 1);
   // Hold window = N*(D+1) + GUARD, minus one for the terminal count
   localparam logic [31:0] HOLD_START = 32'(4 * (DUR_LONG + 1) + GUARD - 1);
   localparam logic [31:0] HOLD_DROP  = 32'(2 * (DUR_SHORT + 1) + GUARD - 1);
   localparam logic [31:0] HOLD_ERROR = 32'(2 * (DUR_LONG + 1) + GUARD - 1);
   localparam logic [31:0] HOLD_VICT  = 32'(13 * (DUR_LONG + 1) + GUARD - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  pending_q, pending_d;
   logic        start_n_q, start_n_d;
   logic [1:0]  type_q, type_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;

   logic        grant;
   logic [1:0]  gtype;
   logic [3:0]  gmask;
   logic [3:0]  clr;
   logic [31:0] hold_load;

   always_comb begin
      if (pending_q[3])      gtype = 2'd3;
      else if (pending_q[2]) gtype = 2'd2;
      else if (pending_q[0]) gtype = 2'd0;
      else                   gtype = 2'd1;
   end

   assign grant = (state_q == S_IDLE) && !mute && (pending_q != 4'd0);
   assign gmask = grant ? (4'b0001 << gtype) : 4'b0000;
   // VICTORY also flushes queued DROP clicks
   assign clr   = gmask | ((grant && gtype == 2'd3) ? 4'b0010 : 4'b0000);

   always_comb begin
      unique case (type_q)
         2'd0:    hold_load = HOLD_START;
         2'd1:    hold_load = HOLD_DROP;
         2'd2:    hold_load = HOLD_ERROR;
         default: hold_load = HOLD_VICT;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_n_d = start_n_q;
      type_d    = type_q;
      busy_d    = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant) begin
               type_d    = gtype;
               start_n_d = 1'b0;
               busy_d    = 1'b1;
               cnt_d     = PULSE_LOAD;
               state_d   = S_PULSE;
            end
         end
         S_PULSE: begin
            if (cnt_q == 32'd0) begin
               start_n_d = 1'b1;
               cnt_d     = hold_load;
               state_d   = S_HOLD;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 32'd0) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if (mute) begin
         pending_d = 4'd0;
         overrun_d = 1'b0;
      end else begin
         pending_d = (pending_q | req) & ~clr;
         overrun_d = |(req & pending_q & ~gmask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 32'd0;
         pending_q <= 4'd0;
         start_n_q <= 1'b1;
         type_q    <= 2'd0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         start_n_q <= start_n_d;
         type_q    <= type_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign snd_start_n = start_n_q;
   assign snd_type    = type_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with shortened durations.
// Table for one DROP melody, hand sequences for the multi-cycle cases.
module tb_sound_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       mute;
   logic       snd_start_n;
   logic [1:0] snd_type;
   logic       busy;
   logic       overrun;

   int tot = 0;
   int bad = 0;
   int busy_cnt = 0;
   int ov_cnt = 0;

   sound_scheduler #(
      .DUR_SHORT(3),
      .DUR_LONG (5),
      .PULSE_LEN(2),
      .GUARD    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mute       (mute),
      .snd_start_n(snd_start_n),
      .snd_type   (snd_type),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim still running");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       mute;
      logic       sn;
      logic       bz;
      logic [1:0] ty;
      logic       ov;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic run_tbl(input int from);
      for (int i = from; i < 19; i++) begin
         rst  = tbl[i].rst;
         req  = tbl[i].req;
         mute = tbl[i].mute;
         @(negedge clk);
         chk($sformatf("v%0d_sn", i), 32'(snd_start_n), 32'(tbl[i].sn));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
         chk($sformatf("v%0d_type", i), 32'(snd_type), 32'(tbl[i].ty));
         chk($sformatf("v%0d_ov", i), 32'(overrun), 32'(tbl[i].ov));
      end
   endtask

   task automatic pulse_req(input logic [3:0] v);
      req = v;
      @(negedge clk);
      req = 4'd0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   task automatic quiet(input int n, input string nm);
      int b0 = busy_cnt;
      repeat (n) @(negedge clk);
      chk(nm, 32'(busy_cnt - b0), 32'd0);
   endtask

   task automatic play(input logic [1:0] et, input int eb,
                       input string nm, output int idle);
      int bl = 0;
      int sl = 0;
      idle = 0;
      while (!busy && idle < 300) begin
         idle++;
         @(negedge clk);
      end
      chk({nm, "_start"}, 32'(busy), 32'd1);
      chk({nm, "_type"}, 32'(snd_type), 32'(et));
      chk({nm, "_sn0"}, 32'(snd_start_n), 32'd0);
      while (busy && bl < 300) begin
         bl++;
         if (!snd_start_n) sl++;
         @(negedge clk);
      end
      chk({nm, "_busylen"}, 32'(bl), 32'(eb));
      chk({nm, "_pulselen"}, 32'(sl), 32'd2);
   endtask

   initial begin
      int idl;
      int b0;
      int o0;

      tbl[0] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[1] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[2] = '{1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      tbl[4] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      for (int i = 5; i < 17; i++)
         tbl[i] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
      tbl[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
      tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};

      rst  = 1'b1;
      req  = 4'd0;
      mute = 1'b0;

      // single DROP: grant two cycles after req, busy 14
      run_tbl(0);
      chk("drop_pend", 32'(dut.pending_q), 32'd0);

      // all four at once: VICTORY, ERROR, START; DROP flushed
      req = 4'hF;
      @(negedge clk);
      req = 4'd0;
      play(2'd3, 84, "all_vic", idl);
      play(2'd2, 18, "all_err", idl);
      chk("all_gap1", 32'(idl), 32'd1);
      play(2'd0, 30, "all_sta", idl);
      chk("all_gap2", 32'(idl), 32'd1);
      quiet(40, "all_nodrop");
      chk("all_pend", 32'(dut.pending_q), 32'd0);

      // overrun: second ERROR req while one is pending
      o0 = ov_cnt;
      pulse_req(4'b0001);
      repeat (6) @(negedge clk);
      pulse_req(4'b0100);
      chk("ov_first", 32'(overrun), 32'd0);
      pulse_req(4'b0100);
      chk("ov_second", 32'(overrun), 32'd1);
      @(negedge clk);
      chk("ov_drop", 32'(overrun), 32'd0);
      chk("ov_count", 32'(ov_cnt - o0), 32'd1);
      wait_idle("ov_sta_end");
      play(2'd2, 18, "ov_err", idl);
      chk("ov_gap", 32'(idl), 32'd1);
      quiet(30, "ov_once");

      // merge: START req held into its own grant cycle
      o0 = ov_cnt;
      req = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      req = 4'd0;
      play(2'd0, 30, "mg_sta", idl);
      chk("mg_ov", 32'(ov_cnt - o0), 32'd0);
      chk("mg_pend", 32'(dut.pending_q), 32'd0);
      quiet(40, "mg_once");

      // mute mid-HOLD with DROP pending
      b0 = busy_cnt;
      pulse_req(4'b0001);
      repeat (8) @(negedge clk);
      pulse_req(4'b0010);
      chk("mu_pend_set", 32'(dut.pending_q), 32'b0010);
      mute = 1'b1;
      @(negedge clk);
      chk("mu_pend_clr", 32'(dut.pending_q), 32'd0);
      wait_idle("mu_end");
      chk("mu_busylen", 32'(busy_cnt - b0), 32'd30);
      quiet(20, "mu_nogrant");
      chk("mu_pend", 32'(dut.pending_q), 32'd0);
      mute = 1'b0;
      pulse_req(4'b0001);
      chk("mu_lat1", 32'(snd_start_n), 32'd1);
      @(negedge clk);
      chk("mu_lat2", 32'(snd_start_n), 32'd0);
      chk("mu_type", 32'(snd_type), 32'd0);
      wait_idle("mu_sta_end");

      // reset during PULSE
      pulse_req(4'b0010);
      @(negedge clk);
      chk("rs_pre", 32'(snd_start_n), 32'd0);
      rst = 1'b1;
      #1;
      chk("rs_sn", 32'(snd_start_n), 32'd1);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_type", 32'(snd_type), 32'd0);
      @(negedge clk);
      run_tbl(1);
      chk("rs_pend", 32'(dut.pending_q), 32'd0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Sequences sound requests from the game logic into the single `game_sounds` player. Latches one pending request per sound type and grants the highest-priority one when the player is free. Drives the player's active-low start strobe and holds its type select stable for the full melody. The player has no busy output, so the scheduler derives melody length itself from the same note counts and durations.

## Interface

Parameters:
- `DUR_SHORT`, 2_000_000: per-note countdown load for DROP; must equal the player's short duration.
- `DUR_LONG`, 5_000_000: per-note countdown load for START/ERROR/VICTORY.
- `PULSE_LEN`, 4: cycles `snd_start_n` is held low per grant (≥3, so the player's 3-stage sync catches it).
- `GUARD`, 8: extra idle cycles appended to each hold window (≥3, so the player sees a high level before the next falling edge).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input 4: request pulses, one bit per type; bit index = type code (0 START, 1 DROP, 2 ERROR, 3 VICTORY).
- `mute` input 1: level; suppresses new grants and discards pending requests.
- `snd_start_n` output 1: to player `start`; idle high, low for `PULSE_LEN` cycles per grant.
- `snd_type` output 2: to player `type`; stable from grant until `busy` falls.
- `busy` output 1: high while a melody is being strobed or played.
- `overrun` output 1: one-cycle pulse when a request hits a type that is already pending.

## Operation

- `pending[3:0]` register. A `req` bit sets its `pending` bit. A `req` bit with that `pending` bit already set leaves it set and raises `overrun` on the next cycle.
- Priority: VICTORY > ERROR > START > DROP.
- Note counts N: START 4, DROP 2, ERROR 2, VICTORY 13. D = `DUR_SHORT` for DROP, else `DUR_LONG`.
- FSM states:
  - IDLE: if `mute`=0 and `pending`≠0, grant the highest-priority type. On grant: latch `snd_type`, clear that `pending` bit, drive `snd_start_n`=0, set `busy`=1, load the pulse counter with `PULSE_LEN`-1, and go to PULSE.
  - PULSE: count down. At 0: `snd_start_n`=1, load the hold counter with N*(D+1)+`GUARD`-1, and go to HOLD.
  - HOLD: count down. At 0: `busy`=0 and go to IDLE.
- A VICTORY grant also clears `pending[1]` (stale drop clicks are discarded).
- A `req` bit for the type being granted, in the grant cycle, merges into that grant: the bit is not re-set and no `overrun` is raised.
- `mute`=1: `pending` is cleared every cycle, `req` is ignored, and no grant is made. A PULSE/HOLD already in progress completes normally.
- Counters are 32-bit unsigned. The worst case, 13*(5_000_001)+`GUARD`, fits.

## Timing

- Reset values: `snd_start_n`=1, `snd_type`=0, `busy`=0, `overrun`=0, `pending`=0, state IDLE, counters 0. Reset mid-melody returns to these values immediately.
- All outputs are registered.
- Latency: a `req` sampled at edge E sets `pending` at E. The grant occurs at edge E+1, when `snd_start_n` falls and `busy` rises. This gives 2 cycles from `req` high to `snd_start_n` low.
- `snd_start_n` is low exactly `PULSE_LEN` cycles.
- `busy` is high exactly `PULSE_LEN` + N*(D+1) + `GUARD` cycles.
- Back-to-back grants: `busy` is low for exactly 1 cycle (the IDLE cycle) between melodies.
- `snd_type` changes only at grant edges.

## Test plan

Parameters for all scenarios: `DUR_SHORT`=3, `DUR_LONG`=5, `PULSE_LEN`=2, `GUARD`=4.

- Single DROP: `req`=0010 for 1 cycle → 2 cycles later `snd_type`=1 and `snd_start_n` low for 2 cycles; `busy` high for 14 cycles; `pending` ends at 0.
- Simultaneous request: `req`=1111 in one cycle → grant order VICTORY (busy 84), ERROR (18), START (30). DROP is cleared by the VICTORY grant and never plays. Exactly one low `busy` cycle separates each melody.
- Overrun: during HOLD, pulse `req[2]` twice → `overrun` pulses once after the second request; ERROR plays once after the current melody.
- Merge: pulse `req[0]` exactly in the START grant cycle → no `overrun`; `pending[0]`=0 afterwards; no second START plays.
- Mute: raise `mute` mid-HOLD with DROP pending → the current melody finishes; `pending` reads 0; no grant occurs. Lower `mute`, pulse `req[0]` → START grants 2 cycles later.
- Reset: assert `rst` while `snd_start_n`=0 in PULSE → `snd_start_n`=1 and `busy`=0 immediately. After deassert, a fresh DROP request behaves as in scenario 1.
